// File: rtl/spi_master_arbiter_if.sv
// Requester, chip-select and SPI-master signals of the SPI transaction arbiter.
// The master modport is the arbiter's view; slave is the requester/SPI side.
interface spi_master_arbiter_if #(
  parameter int unsigned NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req;
  logic [4*NUM_REQ-1:0]  req_len;
  logic [16*NUM_REQ-1:0] req_word;
  logic [NUM_REQ-1:0]    word_ack;
  logic [NUM_REQ-1:0]    rx_dv;
  logic [15:0]           rx_word;
  logic [NUM_REQ-1:0]    done;
  logic [NUM_REQ-1:0]    cs_n;
  logic                  busy;
  logic [15:0]           spi_tx_word;
  logic                  spi_tx_dv;
  logic                  spi_tx_ready;
  logic                  spi_rx_dv;
  logic [15:0]           spi_rx_word;

  modport master (
    input  req, req_len, req_word, spi_tx_ready, spi_rx_dv, spi_rx_word,
    output word_ack, rx_dv, rx_word, done, cs_n, busy, spi_tx_word, spi_tx_dv
  );

  modport slave (
    output req, req_len, req_word, spi_tx_ready, spi_rx_dv, spi_rx_word,
    input  word_ack, rx_dv, rx_word, done, cs_n, busy, spi_tx_word, spi_tx_dv
  );
endinterface

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one 16-bit SPI master between NUM_REQ requesters,
// generating per-requester chip selects with setup, hold and gap timing.
module spi_master_arbiter #(
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned CS_SETUP_CLKS = 4,
  parameter int unsigned CS_HOLD_CLKS  = 4,
  parameter int unsigned CS_GAP_CLKS   = 2
) (
  input logic             i_Clk,
  input logic             i_Rst_L,
  spi_master_arbiter_if.master bus
);

  localparam int unsigned GW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CMAX = (CS_SETUP_CLKS >= CS_HOLD_CLKS) ?
                                 ((CS_SETUP_CLKS >= CS_GAP_CLKS) ? CS_SETUP_CLKS : CS_GAP_CLKS) :
                                 ((CS_HOLD_CLKS  >= CS_GAP_CLKS) ? CS_HOLD_CLKS  : CS_GAP_CLKS);
  localparam int unsigned CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SEND,
    WAIT_RX,
    CS_HOLD,
    CS_GAP
  } state_t;

  state_t         state, state_nxt;
  logic [GW-1:0]  grant, grant_nxt;
  logic [GW-1:0]  last, last_nxt;
  logic [3:0]     remaining, remaining_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;

  logic [GW-1:0]  pick, cand;
  logic           found;
  logic [3:0]     pick_len;
  logic [15:0]    cur_word;
  logic [NUM_REQ-1:0] gsel;

  logic           tx_fire, rx_fire, done_fire;
  logic [NUM_REQ-1:0] cs_n_d, word_ack_d, rx_dv_d, done_d;
  logic [15:0]    rx_word_d, tx_word_d;
  logic           busy_d;

  // Round-robin search starts one past the last grant and wraps.
  always_comb begin
    pick  = last;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = GW'((32'(last) + i) % NUM_REQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign pick_len = bus.req_len[4*pick +: 4];
  assign cur_word = bus.req_word[16*grant +: 16];

  always_comb begin
    gsel        = '0;
    gsel[grant] = 1'b1;
  end

  // State and transaction bookkeeping.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state     <= IDLE;
      grant     <= '0;
      last      <= GW'(NUM_REQ - 1);
      remaining <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      last      <= last_nxt;
      remaining <= remaining_nxt;
      cnt       <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    last_nxt      = last;
    remaining_nxt = remaining;
    cnt_nxt       = cnt + CW'(1);
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (found) begin
          grant_nxt     = pick;
          last_nxt      = pick;
          remaining_nxt = pick_len;
          state_nxt     = CS_SETUP;
        end
      end
      CS_SETUP: begin
        if (cnt == CW'(CS_SETUP_CLKS - 1)) begin
          cnt_nxt   = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        cnt_nxt = '0;
        if (bus.spi_tx_ready) state_nxt = WAIT_RX;
      end
      WAIT_RX: begin
        cnt_nxt = '0;
        if (bus.spi_rx_dv) begin
          if (remaining == 4'd0) begin
            state_nxt = CS_HOLD;
          end else begin
            remaining_nxt = remaining - 4'd1;
            state_nxt     = SEND;
          end
        end
      end
      CS_HOLD: begin
        if (cnt == CW'(CS_HOLD_CLKS - 1)) begin
          cnt_nxt   = '0;
          state_nxt = CS_GAP;
        end
      end
      CS_GAP: begin
        if (cnt == CW'(CS_GAP_CLKS - 1)) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are computed from the next state so that registering them
  // lines up exactly with the state they belong to.
  always_comb begin
    tx_fire   = (state == SEND) && bus.spi_tx_ready;
    rx_fire   = (state == WAIT_RX) && bus.spi_rx_dv;
    done_fire = (state == CS_HOLD) && (cnt == CW'(CS_HOLD_CLKS - 1));

    cs_n_d = '1;
    if (state_nxt inside {CS_SETUP, SEND, WAIT_RX, CS_HOLD}) cs_n_d[grant_nxt] = 1'b0;

    word_ack_d = tx_fire   ? gsel : '0;
    rx_dv_d    = rx_fire   ? gsel : '0;
    done_d     = done_fire ? gsel : '0;
    tx_word_d  = tx_fire   ? cur_word : bus.spi_tx_word;
    rx_word_d  = rx_fire   ? bus.spi_rx_word : bus.rx_word;
    busy_d     = (state_nxt != IDLE);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      bus.cs_n        <= '1;
      bus.word_ack    <= '0;
      bus.rx_dv       <= '0;
      bus.done        <= '0;
      bus.rx_word     <= '0;
      bus.spi_tx_word <= '0;
      bus.spi_tx_dv   <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      bus.cs_n        <= cs_n_d;
      bus.word_ack    <= word_ack_d;
      bus.rx_dv       <= rx_dv_d;
      bus.done        <= done_d;
      bus.rx_word     <= rx_word_d;
      bus.spi_tx_word <= tx_word_d;
      bus.spi_tx_dv   <= tx_fire;
      bus.busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Self-checking bench for spi_master_arbiter: loopback SPI model, event logs
// and a scoreboard of expected received words.
module tb_spi_master_arbiter;
  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned SETUP   = 4;
  localparam int unsigned HOLD    = 4;
  localparam int unsigned GAP     = 2;

  typedef struct packed {
    int unsigned cyc;
    int unsigned idx;
    logic [15:0] word;
  } ev_t;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  spi_master_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  spi_master_arbiter #(
    .NUM_REQ(NUM_REQ),
    .CS_SETUP_CLKS(SETUP),
    .CS_HOLD_CLKS(HOLD),
    .CS_GAP_CLKS(GAP)
  ) dut (
    .i_Clk(clk),
    .i_Rst_L(rst_l),
    .bus(bus)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  int unsigned cyc = 0;
  ev_t tx_ev[$], ack_ev[$], rx_ev[$], done_ev[$], cs_ev[$];
  ev_t exp_rx[$];
  int unsigned rx_rd = 0;

  logic [15:0] wlist [NUM_REQ][16];
  int unsigned word_base [NUM_REQ];
  int unsigned ack_total [NUM_REQ];
  logic [NUM_REQ-1:0] cs_prev = '1;
  int unsigned overlap_cnt = 0;
  int unsigned stray_count = 0;
  int unsigned stray_done = 0;
  bit          pend = 1'b0;
  int unsigned pend_cnt = 0;
  logic [15:0] pend_word = '0;

  function automatic ev_t mk_ev(input int unsigned c, input int unsigned i, input logic [15:0] w);
    ev_t e;
    e.cyc = c; e.idx = i; e.word = w;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int r = 0; r < NUM_REQ; r++) begin
      ack_total[r] = 0;
      word_base[r] = 0;
    end
  end

  // Monitor, requester word sources and a loopback SPI master.
  always @(negedge clk) begin
    int unsigned zi;
    bus.spi_rx_dv = 1'b0;
    if (bus.spi_tx_dv === 1'b1) tx_ev.push_back(mk_ev(cyc, 0, bus.spi_tx_word));
    for (int r = 0; r < NUM_REQ; r++) begin
      if (bus.word_ack[r] === 1'b1) begin
        ack_ev.push_back(mk_ev(cyc, r, 16'h0));
        ack_total[r] = ack_total[r] + 1;
      end
      if (bus.rx_dv[r] === 1'b1) rx_ev.push_back(mk_ev(cyc, r, bus.rx_word));
      if (bus.done[r] === 1'b1) done_ev.push_back(mk_ev(cyc, r, 16'h0));
    end
    if (bus.cs_n !== cs_prev) begin
      zi = NUM_REQ;
      for (int r = NUM_REQ - 1; r >= 0; r--) if (bus.cs_n[r] === 1'b0) zi = r;
      cs_ev.push_back(mk_ev(cyc, zi, 16'(bus.cs_n)));
      cs_prev = bus.cs_n;
    end
    if ($countones(~bus.cs_n) > 1) overlap_cnt++;
    for (int r = 0; r < NUM_REQ; r++)
      bus.req_word[16*r +: 16] = wlist[r][(ack_total[r] - word_base[r]) % 16];
    if (pend) begin
      pend_cnt = pend_cnt - 1;
      if (pend_cnt == 0) begin
        bus.spi_rx_dv   = 1'b1;
        bus.spi_rx_word = pend_word;
        pend = 1'b0;
      end
    end else if (stray_count != stray_done) begin
      stray_done++;
      bus.spi_rx_dv   = 1'b1;
      bus.spi_rx_word = 16'hDEAD;
    end
    if (bus.spi_tx_dv === 1'b1) begin
      pend      = 1'b1;
      pend_cnt  = 3;
      pend_word = bus.spi_tx_word;
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_cs(input int unsigned target, input int unsigned budget);
    int unsigned n = 0;
    while (cs_ev.size() < target && n < budget) begin tick(1); n++; end
  endtask

  task automatic wait_done(input int unsigned target, input int unsigned budget);
    int unsigned n = 0;
    while (done_ev.size() < target && n < budget) begin tick(1); n++; end
  endtask

  task automatic test_reset;
    rst_l = 1'b0;
    bus.req = '0;
    bus.req_len = '0;
    bus.spi_tx_ready = 1'b1;
    for (int r = 0; r < NUM_REQ; r++)
      for (int k = 0; k < 16; k++) wlist[r][k] = '0;
    tick(3);
    checks++;
    if (bus.cs_n !== 2'b11) begin errors++; $display("FAIL reset_cs_n got %b want 11", bus.cs_n); end
    checks++;
    if ({bus.busy, bus.spi_tx_dv, bus.word_ack, bus.rx_dv, bus.done} !== '0) begin
      errors++; $display("FAIL reset_pulses got busy=%b txdv=%b ack=%b rxdv=%b done=%b want all 0",
                         bus.busy, bus.spi_tx_dv, bus.word_ack, bus.rx_dv, bus.done);
    end
    checks++;
    if (bus.rx_word !== 16'h0 || bus.spi_tx_word !== 16'h0) begin
      errors++; $display("FAIL reset_words got rx=%h tx=%h want 0000", bus.rx_word, bus.spi_tx_word);
    end
    rst_l = 1'b1;
    tick(3);
    checks++;
    if (bus.busy !== 1'b0 || bus.cs_n !== 2'b11) begin
      errors++; $display("FAIL idle_after_reset got busy=%b cs_n=%b want 0 11", bus.busy, bus.cs_n);
    end
  endtask

  task automatic test_single_word;
    int unsigned b_tx = tx_ev.size(), b_ack = ack_ev.size(), b_done = done_ev.size(), b_cs = cs_ev.size();
    ev_t e;
    wlist[0][0] = 16'hA5C3;
    word_base[0] = ack_total[0];
    bus.req_len[3:0] = 4'd0;
    exp_rx.push_back(mk_ev(0, 0, 16'hA5C3));
    bus.req[0] = 1'b1;
    wait_cs(b_cs + 1, 20);
    bus.req[0] = 1'b0;
    wait_done(b_done + 1, 200);
    tick(1);
    checks++;
    if (done_ev.size() != b_done + 1 || done_ev[b_done].idx != 0) begin
      errors++; $display("FAIL single_done got %0d dones want 1 for req0", done_ev.size() - b_done);
    end
    checks++;
    if (cs_ev.size() != b_cs + 2 || cs_ev[b_cs].word != 16'h0002 || cs_ev[b_cs+1].word != 16'h0003) begin
      errors++; $display("FAIL single_cs got %0d cs changes want 10 then 11", cs_ev.size() - b_cs);
    end
    checks++;
    if (ack_ev.size() != b_ack + 1 || tx_ev.size() != b_tx + 1 ||
        ack_ev[b_ack].idx != 0 || ack_ev[b_ack].cyc != tx_ev[b_tx].cyc) begin
      errors++; $display("FAIL single_ack got acks=%0d txdv=%0d want 1 coincident for req0",
                         ack_ev.size() - b_ack, tx_ev.size() - b_tx);
    end
    checks++;
    if (tx_ev.size() <= b_tx || cs_ev.size() <= b_cs || tx_ev[b_tx].cyc - cs_ev[b_cs].cyc != SETUP + 1) begin
      errors++; $display("FAIL single_setup got cs-fall-to-txdv=%0d want %0d",
                         (tx_ev.size() > b_tx && cs_ev.size() > b_cs) ? tx_ev[b_tx].cyc - cs_ev[b_cs].cyc : 0,
                         SETUP + 1);
    end
    while (exp_rx.size() > 0) begin
      e = exp_rx.pop_front();
      checks++;
      if (rx_rd >= rx_ev.size() || rx_ev[rx_rd].idx != e.idx || rx_ev[rx_rd].word !== e.word) begin
        errors++; $display("FAIL single_rx got %h want %h for req%0d",
                           (rx_rd < rx_ev.size()) ? rx_ev[rx_rd].word : 16'hxxxx, e.word, e.idx);
      end
      rx_rd++;
    end
    checks++;
    if (cs_ev.size() < b_cs + 2 || rx_ev.size() == 0 || cs_ev[b_cs+1].cyc - rx_ev[rx_ev.size()-1].cyc != HOLD) begin
      errors++; $display("FAIL single_hold got rxdv-to-cs-rise=%0d want %0d",
                         (cs_ev.size() >= b_cs + 2 && rx_ev.size() > 0) ? cs_ev[b_cs+1].cyc - rx_ev[rx_ev.size()-1].cyc : 0,
                         HOLD);
    end
    checks++;
    if (done_ev.size() <= b_done || cs_ev.size() < b_cs + 2 || done_ev[b_done].cyc != cs_ev[b_cs+1].cyc) begin
      errors++; $display("FAIL single_done_timing got done not coincident with cs rise want coincident");
    end
  endtask

  task automatic test_burst;
    int unsigned b_tx = tx_ev.size(), b_ack = ack_ev.size(), b_done = done_ev.size(), b_cs = cs_ev.size();
    int unsigned b_rx = rx_ev.size();
    int unsigned bad;
    ev_t e;
    for (int k = 0; k < 4; k++) wlist[1][k] = 16'(k + 1);
    word_base[1] = ack_total[1];
    bus.req_len[7:4] = 4'd3;
    for (int k = 0; k < 4; k++) exp_rx.push_back(mk_ev(0, 1, 16'(k + 1)));
    bus.req[1] = 1'b1;
    wait_cs(b_cs + 1, 20);
    bus.req[1] = 1'b0;
    wait_done(b_done + 1, 400);
    tick(1);
    checks++;
    if (done_ev.size() != b_done + 1 || done_ev[b_done].idx != 1) begin
      errors++; $display("FAIL burst_done got %0d dones want 1 for req1", done_ev.size() - b_done);
    end
    bad = 0;
    if (tx_ev.size() != b_tx + 4) bad = 1;
    else for (int k = 0; k < 4; k++) if (tx_ev[b_tx+k].word !== 16'(k + 1)) bad = 1;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL burst_tx got %0d tx words want 4 words 1..4", tx_ev.size() - b_tx);
    end
    bad = 0;
    if (ack_ev.size() != b_ack + 4 || tx_ev.size() != b_tx + 4) bad = 1;
    else for (int k = 0; k < 4; k++)
      if (ack_ev[b_ack+k].idx != 1 || ack_ev[b_ack+k].cyc != tx_ev[b_tx+k].cyc) bad = 1;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL burst_ack got %0d acks want 4 coincident with txdv for req1", ack_ev.size() - b_ack);
    end
    checks++;
    if (cs_ev.size() != b_cs + 2 || cs_ev[b_cs].word != 16'h0001 || cs_ev[b_cs+1].word != 16'h0003) begin
      errors++; $display("FAIL burst_cs got %0d cs changes want 01 held then 11", cs_ev.size() - b_cs);
    end
    bad = 0;
    if (rx_ev.size() < b_rx + 4 || tx_ev.size() < b_tx + 4) bad = 1;
    else for (int k = 0; k < 3; k++) if (tx_ev[b_tx+k+1].cyc <= rx_ev[b_rx+k].cyc) bad = 1;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL burst_inflight got a word sent before previous rx want one in flight");
    end
    while (exp_rx.size() > 0) begin
      e = exp_rx.pop_front();
      checks++;
      if (rx_rd >= rx_ev.size() || rx_ev[rx_rd].idx != e.idx || rx_ev[rx_rd].word !== e.word) begin
        errors++; $display("FAIL burst_rx got %h want %h for req%0d",
                           (rx_rd < rx_ev.size()) ? rx_ev[rx_rd].word : 16'hxxxx, e.word, e.idx);
      end
      rx_rd++;
    end
  endtask

  task automatic test_arbitration;
    int unsigned b_done = done_ev.size(), b_cs = cs_ev.size(), b_ov = overlap_cnt;
    int unsigned bad;
    ev_t e;
    wlist[0][0] = 16'h1111; wlist[0][1] = 16'h2222;
    wlist[1][0] = 16'h3333; wlist[1][1] = 16'h4444;
    word_base[0] = ack_total[0];
    word_base[1] = ack_total[1];
    bus.req_len = '0;
    exp_rx.push_back(mk_ev(0, 0, 16'h1111));
    exp_rx.push_back(mk_ev(0, 1, 16'h3333));
    exp_rx.push_back(mk_ev(0, 0, 16'h2222));
    exp_rx.push_back(mk_ev(0, 1, 16'h4444));
    bus.req = 2'b11;
    wait_done(b_done + 4, 600);
    bus.req = '0;
    tick(GAP + 6);
    checks++;
    if (cs_ev.size() != b_cs + 8) begin
      errors++; $display("FAIL arb_grants got %0d cs changes want 8", cs_ev.size() - b_cs);
    end
    bad = 0;
    if (cs_ev.size() < b_cs + 8) bad = 1;
    else for (int k = 0; k < 4; k++)
      if (cs_ev[b_cs+2*k].idx != k % 2 || cs_ev[b_cs+2*k+1].word != 16'h0003) bad = 1;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL arb_order got grant sequence wrong want 0,1,0,1");
    end
    bad = 0;
    if (cs_ev.size() < b_cs + 8) bad = 1;
    else for (int k = 1; k < 4; k++)
      if (cs_ev[b_cs+2*k].cyc - cs_ev[b_cs+2*k-1].cyc < GAP + 1) bad = 1;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL arb_gap got all-high gap below %0d cycles want at least %0d", GAP + 1, GAP + 1);
    end
    checks++;
    if (overlap_cnt != b_ov) begin
      errors++; $display("FAIL arb_overlap got %0d cycles with two CS low want 0", overlap_cnt - b_ov);
    end
    bad = 0;
    if (done_ev.size() < b_done + 4) bad = 1;
    else for (int k = 0; k < 4; k++) if (done_ev[b_done+k].idx != k % 2) bad = 1;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL arb_done got %0d dones out of order want 0,1,0,1", done_ev.size() - b_done);
    end
    while (exp_rx.size() > 0) begin
      e = exp_rx.pop_front();
      checks++;
      if (rx_rd >= rx_ev.size() || rx_ev[rx_rd].idx != e.idx || rx_ev[rx_rd].word !== e.word) begin
        errors++; $display("FAIL arb_rx got %h want %h for req%0d",
                           (rx_rd < rx_ev.size()) ? rx_ev[rx_rd].word : 16'hxxxx, e.word, e.idx);
      end
      rx_rd++;
    end
  endtask

  task automatic test_ready_stall;
    int unsigned b_tx, b_ack, b_done = done_ev.size(), b_cs = cs_ev.size();
    int unsigned c;
    ev_t e;
    bus.spi_tx_ready = 1'b0;
    wlist[0][0] = 16'hBEEF;
    word_base[0] = ack_total[0];
    bus.req_len = '0;
    exp_rx.push_back(mk_ev(0, 0, 16'hBEEF));
    bus.req[0] = 1'b1;
    wait_cs(b_cs + 1, 20);
    bus.req[0] = 1'b0;
    tick(SETUP + 2);
    b_tx = tx_ev.size();
    b_ack = ack_ev.size();
    tick(20);
    checks++;
    if (tx_ev.size() != b_tx || ack_ev.size() != b_ack) begin
      errors++; $display("FAIL stall_no_tx got txdv=%0d ack=%0d while not ready want 0 0",
                         tx_ev.size() - b_tx, ack_ev.size() - b_ack);
    end
    c = cyc;
    bus.spi_tx_ready = 1'b1;
    wait_done(b_done + 1, 200);
    tick(1);
    checks++;
    if (tx_ev.size() != b_tx + 1 || tx_ev[b_tx].cyc != c + 1) begin
      errors++; $display("FAIL stall_dv_timing got txdv at cycle %0d want %0d",
                         (tx_ev.size() > b_tx) ? tx_ev[b_tx].cyc : 0, c + 1);
    end
    checks++;
    if (ack_ev.size() != b_ack + 1 || tx_ev.size() <= b_tx || ack_ev[b_ack].cyc != tx_ev[b_tx].cyc) begin
      errors++; $display("FAIL stall_ack got %0d acks want 1 coincident with txdv", ack_ev.size() - b_ack);
    end
    while (exp_rx.size() > 0) begin
      e = exp_rx.pop_front();
      checks++;
      if (rx_rd >= rx_ev.size() || rx_ev[rx_rd].idx != e.idx || rx_ev[rx_rd].word !== e.word) begin
        errors++; $display("FAIL stall_rx got %h want %h for req%0d",
                           (rx_rd < rx_ev.size()) ? rx_ev[rx_rd].word : 16'hxxxx, e.word, e.idx);
      end
      rx_rd++;
    end
  endtask

  task automatic test_reset_mid_burst;
    int unsigned b_tx = tx_ev.size(), b_done, b_cs;
    int unsigned n = 0;
    ev_t e;
    for (int k = 0; k < 4; k++) wlist[1][k] = 16'(k + 5);
    word_base[1] = ack_total[1];
    bus.req_len = 8'h30;
    exp_rx.push_back(mk_ev(0, 1, 16'h0005));
    bus.req[1] = 1'b1;
    while (tx_ev.size() < b_tx + 2 && n < 200) begin tick(1); n++; end
    checks++;
    if (tx_ev.size() < b_tx + 2) begin
      errors++; $display("FAIL midrst_second_word got %0d words sent want 2", tx_ev.size() - b_tx);
    end
    tick(1);
    b_done = done_ev.size();
    #2;
    rst_l = 1'b0;
    #1;
    checks++;
    if (bus.cs_n !== 2'b11) begin
      errors++; $display("FAIL midrst_cs_async got %b want 11", bus.cs_n);
    end
    checks++;
    if ({bus.busy, bus.spi_tx_dv, bus.word_ack, bus.rx_dv, bus.done} !== '0) begin
      errors++; $display("FAIL midrst_pulses got busy=%b txdv=%b ack=%b rxdv=%b done=%b want all 0",
                         bus.busy, bus.spi_tx_dv, bus.word_ack, bus.rx_dv, bus.done);
    end
    bus.req = '0;
    tick(3);
    rst_l = 1'b1;
    tick(5);
    checks++;
    if (done_ev.size() != b_done) begin
      errors++; $display("FAIL midrst_no_done got %0d dones want 0", done_ev.size() - b_done);
    end
    while (exp_rx.size() > 0) begin
      e = exp_rx.pop_front();
      checks++;
      if (rx_rd >= rx_ev.size() || rx_ev[rx_rd].idx != e.idx || rx_ev[rx_rd].word !== e.word) begin
        errors++; $display("FAIL midrst_rx got %h want %h for req%0d",
                           (rx_rd < rx_ev.size()) ? rx_ev[rx_rd].word : 16'hxxxx, e.word, e.idx);
      end
      rx_rd++;
    end
    checks++;
    if (rx_ev.size() != rx_rd) begin
      errors++; $display("FAIL midrst_extra_rx got %0d unexpected rx words want 0", rx_ev.size() - rx_rd);
    end
    rx_rd = rx_ev.size();
    wlist[0][0] = 16'h0A0A;
    wlist[1][0] = 16'h0B0B;
    word_base[0] = ack_total[0];
    word_base[1] = ack_total[1];
    bus.req_len = '0;
    exp_rx.push_back(mk_ev(0, 0, 16'h0A0A));
    exp_rx.push_back(mk_ev(0, 1, 16'h0B0B));
    b_cs = cs_ev.size();
    bus.req = 2'b11;
    wait_done(b_done + 2, 400);
    bus.req = '0;
    tick(GAP + 6);
    checks++;
    if (cs_ev.size() != b_cs + 4 || cs_ev[b_cs].idx != 0 || cs_ev[b_cs+2].idx != 1) begin
      errors++; $display("FAIL midrst_regrant got first grant %0d want req0 then req1",
                         (cs_ev.size() > b_cs) ? cs_ev[b_cs].idx : 99);
    end
    while (exp_rx.size() > 0) begin
      e = exp_rx.pop_front();
      checks++;
      if (rx_rd >= rx_ev.size() || rx_ev[rx_rd].idx != e.idx || rx_ev[rx_rd].word !== e.word) begin
        errors++; $display("FAIL midrst_after_rx got %h want %h for req%0d",
                           (rx_rd < rx_ev.size()) ? rx_ev[rx_rd].word : 16'hxxxx, e.word, e.idx);
      end
      rx_rd++;
    end
  endtask

  task automatic test_stray_rx;
    int unsigned b_rx = rx_ev.size(), b_tx, b_done, b_cs;
    ev_t e;
    stray_count++;
    tick(4);
    checks++;
    if (rx_ev.size() != b_rx || bus.busy !== 1'b0 || bus.cs_n !== 2'b11) begin
      errors++; $display("FAIL stray_idle got rxdv=%0d busy=%b cs_n=%b want 0 0 11",
                         rx_ev.size() - b_rx, bus.busy, bus.cs_n);
    end
    b_tx = tx_ev.size();
    b_done = done_ev.size();
    b_cs = cs_ev.size();
    wlist[0][0] = 16'h0F0F;
    word_base[0] = ack_total[0];
    bus.req_len = '0;
    exp_rx.push_back(mk_ev(0, 0, 16'h0F0F));
    bus.req[0] = 1'b1;
    wait_cs(b_cs + 1, 20);
    bus.req[0] = 1'b0;
    stray_count++;
    wait_done(b_done + 1, 200);
    tick(1);
    checks++;
    if (tx_ev.size() != b_tx + 1 || cs_ev.size() <= b_cs || tx_ev[b_tx].cyc - cs_ev[b_cs].cyc != SETUP + 1) begin
      errors++; $display("FAIL stray_setup got txdv count %0d or setup changed want 1 word after %0d cycles",
                         tx_ev.size() - b_tx, SETUP + 1);
    end
    checks++;
    if (rx_ev.size() != b_rx + 1) begin
      errors++; $display("FAIL stray_rx_count got %0d rx words want 1", rx_ev.size() - b_rx);
    end
    while (exp_rx.size() > 0) begin
      e = exp_rx.pop_front();
      checks++;
      if (rx_rd >= rx_ev.size() || rx_ev[rx_rd].idx != e.idx || rx_ev[rx_rd].word !== e.word) begin
        errors++; $display("FAIL stray_rx got %h want %h for req%0d",
                           (rx_rd < rx_ev.size()) ? rx_ev[rx_rd].word : 16'hxxxx, e.word, e.idx);
      end
      rx_rd++;
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_burst();
    test_arbitration();
    test_ready_stall();
    test_reset_mid_burst();
    test_stray_rx();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
